// File: rtl/pdcch_scrambler_pkg.sv
// pdcch_scr_pkg: shared types and Gold-sequence step helpers for the PDCCH scrambler.
// Contents: state_t FSM encoding, X1_SEED, x1_step/x2_step (advance an LFSR window n steps).
// Window convention: bit j of a 31-bit state holds x(n+j), so bit 0 is the current output bit.
package pdcch_scr_pkg;

   typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

   localparam logic [30:0] X1_SEED = 31'h1;

   function automatic logic [30:0] x1_step(input logic [30:0] s, input int n);
      logic [30:0] r;
      r = s;
      for (int i = 0; i < n; i++) r = {r[3] ^ r[0], r[30:1]};
      return r;
   endfunction

   function automatic logic [30:0] x2_step(input logic [30:0] s, input int n);
      logic [30:0] r;
      r = s;
      for (int i = 0; i < n; i++) r = {r[3] ^ r[2] ^ r[1] ^ r[0], r[30:1]};
      return r;
   endfunction

endpackage

// File: rtl/pdcch_scrambler_gold_seq_gen.sv
// gold_seq_gen: length-31 Gold sequence generator advancing DATA_WIDTH steps per adv.
// Ports: aclk, reset (async active-low), load (reseed x1=X1_SEED, x2=seed),
//        seed[30:0], adv (advance one beat), c[DATA_WIDTH-1:0] (sequence bits of the current beat).
module gold_seq_gen
   import pdcch_scr_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  aclk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [30:0]           seed,
   input  logic                  adv,
   output logic [DATA_WIDTH-1:0] c
);

   logic [30:0] x1, x2;

   always_ff @(posedge aclk or negedge reset) begin
      if (!reset) begin
         x1 <= '0;
         x2 <= '0;
      end else if (load) begin
         x1 <= X1_SEED;
         x2 <= seed;
      end else if (adv) begin
         x1 <= x1_step(x1, DATA_WIDTH);
         x2 <= x2_step(x2, DATA_WIDTH);
      end
   end

   assign c = x1[DATA_WIDTH-1:0] ^ x2[DATA_WIDTH-1:0];

endmodule

// File: rtl/pdcch_scrambler.sv
// pdcch_scrambler: XORs AXI-stream bytes with the 38.211 Gold sequence seeded by c_init.
// Ports: aclk, reset (async active-low), start (begin codeword, samples c_init), c_init[30:0],
//        s_axis_* (input stream), m_axis_* (scrambled output stream), busy (WARMUP or RUN).
module pdcch_scrambler
   import pdcch_scr_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NC         = 1600
) (
   input  logic                  aclk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [30:0]           c_init,
   input  logic [DATA_WIDTH-1:0] s_axis_data,
   input  logic                  s_axis_valid,
   input  logic                  s_axis_last,
   output logic                  s_axis_ready,
   output logic [DATA_WIDTH-1:0] m_axis_data,
   output logic                  m_axis_valid,
   output logic                  m_axis_last,
   input  logic                  m_axis_ready,
   output logic                  busy
);

   localparam int WARM_CYCLES = NC / DATA_WIDTH;
   localparam int WW          = WARM_CYCLES > 1 ? $clog2(WARM_CYCLES) : 1;

   state_t                state;
   logic [WW-1:0]         warm_cnt;
   logic [DATA_WIDTH-1:0] c;
   logic                  in_hs;

   // Single output register: refill in the same cycle it drains.
   assign s_axis_ready = (state == RUN) && (!m_axis_valid || m_axis_ready);
   assign in_hs        = s_axis_valid && s_axis_ready;
   assign busy         = state != IDLE;

   gold_seq_gen #(.DATA_WIDTH(DATA_WIDTH)) u_gold (
      .aclk  (aclk),
      .reset (reset),
      .load  (start && state == IDLE),
      .seed  (c_init),
      .adv   (state == WARMUP || in_hs),
      .c     (c)
   );

   always_ff @(posedge aclk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         warm_cnt     <= '0;
         m_axis_data  <= '0;
         m_axis_valid <= 1'b0;
         m_axis_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               warm_cnt <= '0;
               state    <= (WARM_CYCLES > 0) ? WARMUP : RUN;
            end
            WARMUP: begin
               warm_cnt <= warm_cnt + 1'b1;
               if (warm_cnt == WW'(WARM_CYCLES - 1)) state <= RUN;
            end
            RUN: if (in_hs && s_axis_last) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (in_hs) begin
            m_axis_data  <= s_axis_data ^ c;
            m_axis_last  <= s_axis_last;
            m_axis_valid <= 1'b1;
         end else if (m_axis_ready) begin
            m_axis_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pdcch_scrambler.sv
// tb_pdcch_scrambler: directed and randomized bench for pdcch_scrambler (NC=0 and NC=1600 instances).
module tb_pdcch_scrambler;

   logic        aclk, reset, start, sel;
   logic [30:0] c_init;
   logic [7:0]  s_data;
   logic        s_valid, s_last, m_ready;
   logic        s_ready0, m_valid0, m_last0, busy0;
   logic        s_ready1, m_valid1, m_last1, busy1;
   logic [7:0]  m_data0, m_data1;
   logic        sr, mv, ml, bz;
   logic [7:0]  md;
   int          checks = 0, errors = 0;
   bit          x1a[0:4095], x2a[0:4095], cref[0:4095];

   pdcch_scrambler #(.DATA_WIDTH(8), .NC(0)) dut0 (
      .aclk(aclk), .reset(reset), .start(start && !sel), .c_init(c_init),
      .s_axis_data(s_data), .s_axis_valid(s_valid), .s_axis_last(s_last), .s_axis_ready(s_ready0),
      .m_axis_data(m_data0), .m_axis_valid(m_valid0), .m_axis_last(m_last0), .m_axis_ready(m_ready),
      .busy(busy0)
   );

   pdcch_scrambler #(.DATA_WIDTH(8), .NC(1600)) dut1 (
      .aclk(aclk), .reset(reset), .start(start && sel), .c_init(c_init),
      .s_axis_data(s_data), .s_axis_valid(s_valid), .s_axis_last(s_last), .s_axis_ready(s_ready1),
      .m_axis_data(m_data1), .m_axis_valid(m_valid1), .m_axis_last(m_last1), .m_axis_ready(m_ready),
      .busy(busy1)
   );

   assign sr = sel ? s_ready1 : s_ready0;
   assign mv = sel ? m_valid1 : m_valid0;
   assign ml = sel ? m_last1  : m_last0;
   assign md = sel ? m_data1  : m_data0;
   assign bz = sel ? busy1    : busy0;

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_s_ready"}, 32'(sr), 0);
      chk({pfx, "_m_valid"}, 32'(mv), 0);
      chk({pfx, "_m_last"},  32'(ml), 0);
      chk({pfx, "_m_data"},  32'(md), 0);
      chk({pfx, "_busy"},    32'(bz), 0);
   endtask

   // Reference Gold sequence straight from the recurrences: c(n) = x1(n+nc) ^ x2(n+nc).
   task automatic gen_ref(input logic [30:0] ci, input int nc, input int nbits);
      for (int n = 0; n < 31; n++) begin
         x1a[n] = (n == 0);
         x2a[n] = ci[n];
      end
      for (int n = 0; n < nc + nbits; n++) begin
         x1a[n+31] = x1a[n+3] ^ x1a[n];
         x2a[n+31] = x2a[n+3] ^ x2a[n+2] ^ x2a[n+1] ^ x2a[n];
      end
      for (int n = 0; n < nbits; n++) cref[n] = x1a[n+nc] ^ x2a[n+nc];
   endtask

   // One codeword on the selected instance; bp adds random input gaps and output stalls,
   // spur re-pulses start mid-codeword, rst_at pulls reset while that beat is presented.
   task automatic run(input logic [30:0] ci, input int nb, input int nc, input bit bp,
                      input int spur, input int rst_at);
      logic [7:0] din[0:127];
      logic [7:0] dexp[0:127];
      logic [7:0] hold;
      int         ii, oi, cyc;
      bit         stalled, in_hs, out_hs;
      ii = 0; oi = 0; stalled = 0; hold = 0;
      gen_ref(ci, nc, nb * 8);
      for (int k = 0; k < nb; k++) begin
         din[k] = 8'($urandom);
         for (int b = 0; b < 8; b++) dexp[k][b] = din[k][b] ^ cref[8*k+b];
      end
      c_init = ci; start = 1'b1;
      @(posedge aclk); #1;
      start = 1'b0; c_init = 31'($urandom);
      cyc = 0;
      while (!sr && cyc < 1000) begin
         @(posedge aclk); #1;
         cyc++;
      end
      chk("ready_latency", cyc, nc / 8);
      cyc = 0;
      while (oi < nb && cyc < 5000) begin
         if (stalled) begin
            chk("stall_valid", 32'(mv), 1);
            chk("stall_data", 32'(md), 32'(hold));
         end
         m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         s_valid = (ii < nb) && (!bp || $urandom_range(0, 3) != 0);
         s_data  = ii < nb ? din[ii] : 8'h00;
         s_last  = (ii == nb - 1);
         if (ii == spur) begin
            start = 1'b1; c_init = ~ci;
         end
         #1;
         if (ii == rst_at) begin
            #1 reset = 1'b0;
            #1 chk_zero("rst_async");
            s_valid = 1'b0; s_last = 1'b0; start = 1'b0; m_ready = 1'b1;
            #3 reset = 1'b1;
            @(posedge aclk); #1;
            chk("rst_idle_busy", 32'(bz), 0);
            chk("rst_idle_ready", 32'(sr), 0);
            return;
         end
         in_hs  = s_valid && sr;
         out_hs = mv && m_ready;
         if (out_hs) begin
            chk("data", 32'(md), 32'(dexp[oi]));
            chk("last", 32'(ml), 32'(oi == nb - 1));
            oi++;
         end
         stalled = mv && !m_ready;
         hold    = md;
         @(posedge aclk); #1;
         start = 1'b0;
         if (in_hs) ii++;
         cyc++;
      end
      s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
      chk("beats_out", oi, nb);
      chk("no_extra", 32'(mv), 0);
      chk("busy_end", 32'(bz), 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; sel = 1'b0; c_init = '0;
      s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
      #3 reset = 1'b0;
      #1 chk_zero("reset0");
      sel = 1'b1;
      #1 chk_zero("reset1");
      sel = 1'b0;
      #5 reset = 1'b1;
      @(posedge aclk); #1;

      // NC=0: c_init=0 gives c=0x01; a start alongside the last beat is ignored.
      c_init = 31'h0; start = 1'b1;
      @(posedge aclk); #1;
      start = 1'b0;
      chk("nc0_ready", 32'(sr), 1);
      chk("nc0_busy", 32'(bz), 1);
      s_valid = 1'b1; s_data = 8'h00; s_last = 1'b1; start = 1'b1; c_init = 31'h5;
      @(posedge aclk); #1;
      start = 1'b0; s_valid = 1'b0;
      chk("t1_data", 32'(md), 32'h01);
      chk("t1_last", 32'(ml), 1);
      chk("t1_valid", 32'(mv), 1);
      chk("t1_busy", 32'(bz), 0);

      // NC=0: all-ones seed gives c=0xFE.
      c_init = 31'h7FFF_FFFF; start = 1'b1;
      @(posedge aclk); #1;
      start = 1'b0;
      chk("t2_busy", 32'(bz), 1);
      chk("t2_drained", 32'(mv), 0);
      s_valid = 1'b1; s_data = 8'h00; s_last = 1'b1;
      @(posedge aclk); #1;
      s_valid = 1'b0;
      chk("t2_data", 32'(md), 32'hFE);
      chk("t2_busy_end", 32'(bz), 0);

      // Start on the cycle right after the last beat takes the new seed.
      c_init = 31'h0; start = 1'b1;
      @(posedge aclk); #1;
      start = 1'b0;
      chk("t3_busy", 32'(bz), 1);
      s_valid = 1'b1; s_data = 8'hFF; s_last = 1'b1;
      @(posedge aclk); #1;
      s_valid = 1'b0; s_last = 1'b0;
      chk("t3_data", 32'(md), 32'hFE);
      @(posedge aclk); #1;

      run(31'($urandom), 20, 0, 1'b1, -1, -1);

      sel = 1'b1;
      #1;
      run(31'h1234, 108, 1600, 1'b0, -1, -1);
      run(31'h1234, 50, 1600, 1'b1, -1, -1);
      run(31'($urandom), 30, 1600, 1'b1, 12, -1);
      run(31'h2BCD, 40, 1600, 1'b0, -1, 20);
      run(31'h2BCD, 4, 1600, 1'b0, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
